store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//  FIFO store buffer between the D-cache store-hit path and the cache/backing-memory write port.
//  Accepts store-hit enqueues (sb_enq_*) from the D-cache and retires them in program order on the drain port (sb_drain_*).
//  Drained entries are merged into the D-cache line and written through to backing memory.
//  Provides combinational byte-granular load forwarding so loads see stores that have not yet drained.
// PARAMETERS
//  DEPTH       4   number of entries (power of 2, >=2)
//  PTR_BITS    2   log2(DEPTH)
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  reset            in   1   synchronous, active-low: 0 = reset, sampled on clk rising edge
//  sb_enq_valid     in   1   enqueue request, one store per cycle
//  sb_enq_addr      in   32  byte address of store
//  sb_enq_data      in   32  store data, lane-aligned
//  sb_enq_byte_en   in   4   byte enables
//  drain_ready      in   1   cache idle and memory write port free; a head entry is popped when drain_valid && drain_ready
//  sb_drain_valid   out  1   head entry presented
//  sb_drain_addr    out  32  head address
//  sb_drain_data    out  32  head data
//  sb_drain_byte_en out  4   head byte enables
//  fwd_addr         in   32  load byte address for forwarding lookup
//  fwd_hit          out  1   at least one valid entry matches fwd_addr[31:2]
//  fwd_data         out  32  forwarded bytes, youngest-wins per byte
//  fwd_byte_en      out  4   bytes covered by buffered stores
//  sb_full          out  1   count == DEPTH; pipeline must stall stores
//  sb_empty         out  1   count == 0
//  sb_count         out  PTR_BITS+1  occupancy
//  sb_overflow      out  1   sticky: enqueue attempted while full
// BEHAVIOUR
//  - Storage: DEPTH entries {addr, data, byte_en, valid}. head_ptr and tail_ptr wrap modulo DEPTH. count is PTR_BITS+1 wide.
//  - Reset (reset==0 at edge):
//    - head_ptr = tail_ptr = 0, count = 0, all valid = 0, overflow = 0.
//    - Outputs: sb_drain_valid 0, sb_empty 1, sb_full 0, sb_count 0, fwd_hit 0, fwd_byte_en 0.
//    - Reset mid-drain discards all pending entries; they are not written to memory.
//  - Enqueue: if sb_enq_valid && !sb_full, write the entry at tail_ptr, set its valid bit, and advance tail_ptr (wrapping).
//  - Enqueue while full: the entry is dropped and sb_overflow is set. sb_overflow is cleared only by reset.
//  - Drain:
//    - sb_drain_valid = !sb_empty, combinationally from registered state.
//    - sb_drain_* present the entry at head_ptr and are 0 when empty.
//    - On drain_valid && drain_ready: clear the head valid bit and advance head_ptr (wrapping).
//    - Entry latency: enqueue at edge N makes drain_valid visible after edge N, so the earliest pop is at edge N+1.
//  - Simultaneous enqueue and pop:
//    - Not full: both occur and count is unchanged.
//    - Full: the pop occurs and the enqueue is dropped with overflow set, because full is evaluated from pre-edge state.
//    - Single entry: the pop retires the old head and the new entry becomes head.
//  - count update: count_next = count + enq_accept - pop. full/empty/count are derived from the registered count.
//  - Forwarding (combinational, uses the current registered entries including the head being popped this cycle):
//    - Match = valid && addr[31:2] == fwd_addr[31:2].
//    - Walk entries from oldest (head) to youngest. For each byte lane b of a match with byte_en[b], fwd_data[b] = that entry's byte.
//    - Younger entries override older ones for the same lane.
//    - fwd_byte_en = OR of matched byte_en. fwd_hit = any match. Unmatched lanes of fwd_data are 0.
//  - Ordering: stores retire strictly FIFO. There is no coalescing, even for identical addresses.
// TESTING
//  T1 reset: hold reset=0 for 2 cycles -> sb_empty=1, sb_count=0, sb_drain_valid=0, sb_overflow=0.
//  T2 fill/drain: enqueue A=0x100/D=0x11111111, B=0x104/D=0x22222222 with drain_ready=0 -> count=2, head=A.
//     Then drain_ready=1 -> A popped, then B popped, then empty=1.
//  T3 full+wrap: enqueue 4 entries -> sb_full=1. A 5th enqueue -> dropped, sb_overflow=1.
//     Pop 2, enqueue 2 -> tail wraps and FIFO order is preserved across the wrap.
//  T4 simultaneous: count=1, enq 0x200 and pop in the same cycle -> count=1, head=0x200.
//     count=4 with enq+pop -> count=3, overflow=1.
//  T5 forward: enqueue 0x300/0xAABBCCDD/be=1111, then 0x300/0x00001122/be=0011.
//     fwd_addr=0x302 -> fwd_hit=1, fwd_byte_en=1111, fwd_data=0xAABB1122.
//     fwd_addr=0x304 -> fwd_hit=0.
//  T6 reset mid-op: 3 entries pending, reset=0 for 1 cycle -> empty=1 and no further drain_valid.

Source files
------------

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   FIFO store buffer between the D-cache store-hit path and the cache /
//   backing-memory write port. Store hits are enqueued at the tail and
//   retired strictly in program order from the head. Entries are never
//   coalesced. A combinational byte-granular forwarding lookup lets loads
//   see stores that have not drained yet; the youngest store wins per byte.
//
// Ports
//   clk              in   1           rising-edge clock
//   reset            in   1           synchronous, active-low (0 = reset)
//   sb_enq_valid     in   1           enqueue request, one store per cycle
//   sb_enq_addr      in   32          store byte address
//   sb_enq_data      in   32          store data, lane-aligned
//   sb_enq_byte_en   in   4           store byte enables
//   drain_ready      in   1           write port free; head pops when valid && ready
//   sb_drain_valid   out  1           head entry presented
//   sb_drain_addr    out  32          head address (0 when empty)
//   sb_drain_data    out  32          head data (0 when empty)
//   sb_drain_byte_en out  4           head byte enables (0 when empty)
//   fwd_addr         in   32          load byte address for forwarding
//   fwd_hit          out  1           some valid entry matches fwd_addr[31:2]
//   fwd_data         out  32          forwarded bytes, unmatched lanes 0
//   fwd_byte_en      out  4           lanes covered by buffered stores
//   sb_full          out  1           count == DEPTH
//   sb_empty         out  1           count == 0
//   sb_count         out  PTR_BITS+1  occupancy
//   sb_overflow      out  1           sticky: enqueue attempted while full
// ---------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sb_enq_valid,
    input  logic [31:0]         sb_enq_addr,
    input  logic [31:0]         sb_enq_data,
    input  logic [3:0]          sb_enq_byte_en,
    input  logic                drain_ready,
    output logic                sb_drain_valid,
    output logic [31:0]         sb_drain_addr,
    output logic [31:0]         sb_drain_data,
    output logic [3:0]          sb_drain_byte_en,
    input  logic [31:0]         fwd_addr,
    output logic                fwd_hit,
    output logic [31:0]         fwd_data,
    output logic [3:0]          fwd_byte_en,
    output logic                sb_full,
    output logic                sb_empty,
    output logic [PTR_BITS:0]   sb_count,
    output logic                sb_overflow
);

    localparam logic [PTR_BITS:0] LP_FULL_CNT = (PTR_BITS+1)'(DEPTH);

    // Entry payload is not reset; only the valid bits and pointers are.
    logic [31:0]         r_addr [DEPTH];
    logic [31:0]         r_data [DEPTH];
    logic [3:0]          r_be   [DEPTH];
    logic [DEPTH-1:0]    r_valid;
    logic [PTR_BITS-1:0] r_head;
    logic [PTR_BITS-1:0] r_tail;
    logic [PTR_BITS:0]   r_count;
    logic                r_overflow;

    logic w_full;
    logic w_empty;
    logic w_enq_acc;
    logic w_pop;

    // Forwarding compares word addresses only; the byte offset is irrelevant.
    logic [1:0] w_unused_fwd_lo;
    assign w_unused_fwd_lo = fwd_addr[1:0];

    // Full/empty come from the registered count, so an enqueue arriving in
    // the same cycle as a pop from a full buffer is still dropped.
    assign w_full    = (r_count == LP_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_enq_acc = sb_enq_valid && !w_full;
    assign w_pop     = !w_empty && drain_ready;

    assign sb_full          = w_full;
    assign sb_empty         = w_empty;
    assign sb_count         = r_count;
    assign sb_overflow      = r_overflow;
    assign sb_drain_valid   = !w_empty;
    assign sb_drain_addr    = w_empty ? '0 : r_addr[r_head];
    assign sb_drain_data    = w_empty ? '0 : r_data[r_head];
    assign sb_drain_byte_en = w_empty ? '0 : r_be[r_head];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_valid    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (sb_enq_valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            // The tail slot can only equal the head slot when full (no
            // enqueue) or empty (no pop), so these two writes never collide.
            if (w_enq_acc) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            r_count <= r_count + (PTR_BITS+1)'(w_enq_acc) - (PTR_BITS+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq_acc) begin
            r_addr[r_tail] <= sb_enq_addr;
            r_data[r_tail] <= sb_enq_data;
            r_be[r_tail]   <= sb_enq_byte_en;
        end
    end

    // Walk oldest to youngest so a later match overwrites earlier lanes.
    always_comb begin
        logic [PTR_BITS-1:0] w_idx;
        fwd_hit     = 1'b0;
        fwd_data    = '0;
        fwd_byte_en = '0;
        w_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PTR_BITS'(i);
            if (r_valid[w_idx] && (r_addr[w_idx][31:2] == fwd_addr[31:2])) begin
                fwd_hit = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (r_be[w_idx][b]) begin
                        fwd_data[8*b +: 8] = r_data[w_idx][8*b +: 8];
                        fwd_byte_en[b]     = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        sb_enq_valid;
    logic [31:0] sb_enq_addr;
    logic [31:0] sb_enq_data;
    logic [3:0]  sb_enq_byte_en;
    logic        drain_ready;
    logic        sb_drain_valid;
    logic [31:0] sb_drain_addr;
    logic [31:0] sb_drain_data;
    logic [3:0]  sb_drain_byte_en;
    logic [31:0] fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [3:0]  fwd_byte_en;
    logic        sb_full;
    logic        sb_empty;
    logic [2:0]  sb_count;
    logic        sb_overflow;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4), .PTR_BITS(2)) dut (
        .clk(clk), .reset(reset),
        .sb_enq_valid(sb_enq_valid), .sb_enq_addr(sb_enq_addr),
        .sb_enq_data(sb_enq_data), .sb_enq_byte_en(sb_enq_byte_en),
        .drain_ready(drain_ready),
        .sb_drain_valid(sb_drain_valid), .sb_drain_addr(sb_drain_addr),
        .sb_drain_data(sb_drain_data), .sb_drain_byte_en(sb_drain_byte_en),
        .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .fwd_byte_en(fwd_byte_en),
        .sb_full(sb_full), .sb_empty(sb_empty), .sb_count(sb_count),
        .sb_overflow(sb_overflow)
    );

    // Reference model: the buffer is just an ordered list of stores.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;
    ent_t q[$];
    logic m_ovf;

    function automatic void model_fwd(input logic [31:0] fa, output logic hit,
                                      output logic [3:0] be, output logic [31:0] d);
        hit = 1'b0; be = '0; d = '0;
        foreach (q[i]) begin
            if (q[i].a[31:2] == fa[31:2]) begin
                hit = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (q[i].be[b]) begin
                        d[8*b +: 8] = q[i].d[8*b +: 8];
                        be[b] = 1'b1;
                    end
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_enq_valid = 1'b0; sb_enq_addr = '0; sb_enq_data = '0;
        sb_enq_byte_en = '0; drain_ready = 1'b0;
    endtask

    task automatic set_enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        sb_enq_valid = 1'b1; sb_enq_addr = a; sb_enq_data = d; sb_enq_byte_en = be;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        fwd_addr = 32'h0;
        reset = 1'b0;
        tick();
        tick();
        vectors++; if (sb_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", sb_empty); end
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", sb_count); end
        vectors++; if (sb_drain_valid !== 1'b0) begin miscompares++; $display("FAIL reset_drain_valid got %b want 0", sb_drain_valid); end
        vectors++; if (sb_overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", sb_overflow); end
        vectors++; if (sb_full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", sb_full); end
        vectors++; if (fwd_hit !== 1'b0 || fwd_byte_en !== 4'h0) begin miscompares++; $display("FAIL reset_fwd got hit=%b be=%h want 0/0", fwd_hit, fwd_byte_en); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fill_drain();
        idle();
        set_enq(32'h100, 32'h11111111, 4'hF); tick();
        set_enq(32'h104, 32'h22222222, 4'hF); tick();
        idle();
        vectors++; if (sb_count !== 3'd2) begin miscompares++; $display("FAIL fd_count got %0d want 2", sb_count); end
        vectors++; if (sb_drain_valid !== 1'b1 || sb_drain_addr !== 32'h100 || sb_drain_data !== 32'h11111111)
            begin miscompares++; $display("FAIL fd_head_A got v=%b a=%h d=%h want 1/100/11111111", sb_drain_valid, sb_drain_addr, sb_drain_data); end
        drain_ready = 1'b1;
        tick();
        vectors++; if (sb_drain_addr !== 32'h104 || sb_drain_data !== 32'h22222222 || sb_count !== 3'd1)
            begin miscompares++; $display("FAIL fd_head_B got a=%h d=%h c=%0d want 104/22222222/1", sb_drain_addr, sb_drain_data, sb_count); end
        tick();
        vectors++; if (sb_empty !== 1'b1 || sb_drain_valid !== 1'b0 || sb_drain_addr !== 32'h0)
            begin miscompares++; $display("FAIL fd_empty got e=%b v=%b a=%h want 1/0/0", sb_empty, sb_drain_valid, sb_drain_addr); end
        idle();
    endtask

    task automatic test_full_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'h408; exp_a[1] = 32'h40C; exp_a[2] = 32'h500; exp_a[3] = 32'h504;
        idle();
        for (int i = 0; i < 4; i++) begin
            set_enq(32'h400 + 32'(4*i), 32'hA0 + 32'(i), 4'hF);
            tick();
        end
        idle();
        vectors++; if (sb_full !== 1'b1 || sb_count !== 3'd4) begin miscompares++; $display("FAIL fw_full got f=%b c=%0d want 1/4", sb_full, sb_count); end
        set_enq(32'h4F0, 32'hDEAD, 4'hF); tick(); idle();
        vectors++; if (sb_overflow !== 1'b1 || sb_count !== 3'd4 || sb_drain_addr !== 32'h400)
            begin miscompares++; $display("FAIL fw_overflow got o=%b c=%0d h=%h want 1/4/400", sb_overflow, sb_count, sb_drain_addr); end
        drain_ready = 1'b1; tick(); tick(); idle();
        vectors++; if (sb_count !== 3'd2 || sb_drain_addr !== 32'h408)
            begin miscompares++; $display("FAIL fw_pop2 got c=%0d h=%h want 2/408", sb_count, sb_drain_addr); end
        set_enq(32'h500, 32'hB0, 4'hF); tick();
        set_enq(32'h504, 32'hB1, 4'hF); tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (sb_drain_valid !== 1'b1 || sb_drain_addr !== exp_a[i])
                begin miscompares++; $display("FAIL fw_order[%0d] got v=%b a=%h want 1/%h", i, sb_drain_valid, sb_drain_addr, exp_a[i]); end
            drain_ready = 1'b1;
            tick();
        end
        idle();
        vectors++; if (sb_empty !== 1'b1 || sb_overflow !== 1'b1)
            begin miscompares++; $display("FAIL fw_sticky got e=%b o=%b want 1/1", sb_empty, sb_overflow); end
        do_reset();
        vectors++; if (sb_overflow !== 1'b0) begin miscompares++; $display("FAIL fw_ovf_clear got %b want 0", sb_overflow); end
    endtask

    task automatic test_simultaneous();
        idle();
        set_enq(32'h1F0, 32'h1, 4'hF); tick();
        set_enq(32'h200, 32'h2, 4'hF); drain_ready = 1'b1; tick(); idle();
        vectors++; if (sb_count !== 3'd1 || sb_drain_addr !== 32'h200 || sb_drain_data !== 32'h2)
            begin miscompares++; $display("FAIL sim_one got c=%0d h=%h d=%h want 1/200/2", sb_count, sb_drain_addr, sb_drain_data); end
        for (int i = 1; i < 4; i++) begin
            set_enq(32'h200 + 32'(4*i), 32'(2 + i), 4'hF);
            tick();
        end
        set_enq(32'h210, 32'h99, 4'hF); drain_ready = 1'b1; tick(); idle();
        vectors++; if (sb_count !== 3'd3 || sb_overflow !== 1'b1 || sb_drain_addr !== 32'h204)
            begin miscompares++; $display("FAIL sim_full got c=%0d o=%b h=%h want 3/1/204", sb_count, sb_overflow, sb_drain_addr); end
        do_reset();
    endtask

    task automatic test_forward();
        idle();
        set_enq(32'h300, 32'hAABBCCDD, 4'hF); tick();
        set_enq(32'h300, 32'h00001122, 4'h3); tick();
        idle();
        fwd_addr = 32'h302; #1;
        vectors++; if (fwd_hit !== 1'b1 || fwd_byte_en !== 4'hF || fwd_data !== 32'hAABB1122)
            begin miscompares++; $display("FAIL fwd_hit got h=%b be=%h d=%h want 1/f/aabb1122", fwd_hit, fwd_byte_en, fwd_data); end
        fwd_addr = 32'h304; #1;
        vectors++; if (fwd_hit !== 1'b0 || fwd_byte_en !== 4'h0 || fwd_data !== 32'h0)
            begin miscompares++; $display("FAIL fwd_miss got h=%b be=%h d=%h want 0/0/0", fwd_hit, fwd_byte_en, fwd_data); end
        // After the full-word store drains, only the younger half-word remains.
        drain_ready = 1'b1; tick(); idle();
        fwd_addr = 32'h300; #1;
        vectors++; if (fwd_hit !== 1'b1 || fwd_byte_en !== 4'h3 || fwd_data !== 32'h00001122)
            begin miscompares++; $display("FAIL fwd_partial got h=%b be=%h d=%h want 1/3/00001122", fwd_hit, fwd_byte_en, fwd_data); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        idle();
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h700 + 32'(4*i), 32'h70 + 32'(i), 4'hF);
            tick();
        end
        idle();
        drain_ready = 1'b1;
        reset = 1'b0; tick(); reset = 1'b1;
        fwd_addr = 32'h704; #1;
        vectors++; if (sb_empty !== 1'b1 || sb_drain_valid !== 1'b0 || sb_count !== 3'd0 || fwd_hit !== 1'b0)
            begin miscompares++; $display("FAIL mid_reset got e=%b v=%b c=%0d fh=%b want 1/0/0/0", sb_empty, sb_drain_valid, sb_count, fwd_hit); end
        tick(); tick();
        vectors++; if (sb_drain_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_stay got v=%b want 0", sb_drain_valid); end
        idle();
    endtask

    task automatic test_random();
        logic        e_hit;
        logic [3:0]  e_fbe;
        logic [31:0] e_fd;
        logic        e_full;
        do_reset();
        q.delete();
        m_ovf = 1'b0;
        for (int n = 0; n < 400; n++) begin
            sb_enq_valid   = ($urandom_range(0, 99) < 60);
            sb_enq_addr    = 32'h600 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3));
            sb_enq_data    = $urandom;
            sb_enq_byte_en = 4'($urandom_range(0, 15));
            drain_ready    = ($urandom_range(0, 99) < 45);
            fwd_addr       = 32'h600 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            #1;
            model_fwd(fwd_addr, e_hit, e_fbe, e_fd);
            vectors++;
            if (sb_count !== 3'(q.size()) || sb_empty !== (q.size() == 0) || sb_full !== (q.size() == 4) ||
                sb_overflow !== m_ovf || sb_drain_valid !== (q.size() != 0)) begin
                miscompares++;
                $display("FAIL rnd_state[%0d] got c=%0d e=%b f=%b o=%b v=%b want c=%0d o=%b", n,
                         sb_count, sb_empty, sb_full, sb_overflow, sb_drain_valid, q.size(), m_ovf);
            end
            vectors++;
            if (q.size() != 0) begin
                if (sb_drain_addr !== q[0].a || sb_drain_data !== q[0].d || sb_drain_byte_en !== q[0].be) begin
                    miscompares++;
                    $display("FAIL rnd_head[%0d] got %h/%h/%h want %h/%h/%h", n, sb_drain_addr, sb_drain_data,
                             sb_drain_byte_en, q[0].a, q[0].d, q[0].be);
                end
            end else if (sb_drain_addr !== 32'h0 || sb_drain_data !== 32'h0 || sb_drain_byte_en !== 4'h0) begin
                miscompares++;
                $display("FAIL rnd_head_empty[%0d] got %h/%h/%h want 0/0/0", n, sb_drain_addr, sb_drain_data, sb_drain_byte_en);
            end
            vectors++;
            if (fwd_hit !== e_hit || fwd_byte_en !== e_fbe || fwd_data !== e_fd) begin
                miscompares++;
                $display("FAIL rnd_fwd[%0d] addr=%h got %b/%h/%h want %b/%h/%h", n, fwd_addr,
                         fwd_hit, fwd_byte_en, fwd_data, e_hit, e_fbe, e_fd);
            end
            // Advance the model with the inputs present at this edge.
            e_full = (q.size() == 4);
            if (sb_enq_valid && e_full) m_ovf = 1'b1;
            if (drain_ready && q.size() != 0) void'(q.pop_front());
            if (sb_enq_valid && !e_full) q.push_back('{a: sb_enq_addr, d: sb_enq_data, be: sb_enq_byte_en});
            tick();
        end
        idle();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        fwd_addr = 32'h0;
        test_reset();
        test_fill_drain();
        test_full_wrap();
        test_simultaneous();
        test_forward();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
